// File: rtl/nv_nvdla_cmac_reg_group_ctrl.sv
// Ping-pong register-group sequencer for CMAC: tracks SW op_en per group and hands
// enabled groups to the MAC datapath in order, with a start gap after each switch.
module nv_nvdla_cmac_reg_group_ctrl #(
    parameter int unsigned START_GAP = 2,
    parameter int unsigned GAP_W     = 4
) (
    input  logic       nvdla_core_clk,
    input  logic       nvdla_core_rstn,
    input  logic       producer,
    input  logic       op_en_trigger,
    input  logic       op_en_wr_data,
    input  logic       dp2reg_done,
    output logic       consumer,
    output logic [1:0] status_0,
    output logic [1:0] status_1,
    output logic       op_en_0,
    output logic       op_en_1,
    output logic       reg2dp_op_en,
    output logic [1:0] done_intr,
    output logic       err_wr_busy
);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(START_GAP);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;

    logic [1:0]       r_op_en;
    logic             r_consumer;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [1:0]       r_done_intr;
    logic             r_err_wr_busy;

    logic [1:0]       w_op_en_nxt;
    logic             w_consumer_nxt;
    logic [GAP_W-1:0] w_gap_cnt_nxt;
    logic [1:0]       w_done_intr_nxt;
    logic             w_err_wr_busy_nxt;

    logic             w_run;
    logic             w_done_acc;
    logic             w_wr_one;
    logic             w_wr_set;
    logic             w_wr_err;

    function automatic logic [1:0] f_status(input logic en, input logic is_consumer);
        if (!en) begin
            return ST_IDLE;
        end else if (is_consumer) begin
            return ST_RUNNING;
        end else begin
            return ST_PENDING;
        end
    endfunction

    // Datapath may run only once the gap after a consumer switch has drained.
    assign w_run      = r_op_en[r_consumer] & (r_gap_cnt == '0);
    assign w_done_acc = dp2reg_done & w_run;
    assign w_wr_one   = op_en_trigger & op_en_wr_data;
    assign w_wr_set   = w_wr_one & ~r_op_en[producer];
    assign w_wr_err   = w_wr_one &  r_op_en[producer];

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            r_op_en       <= 2'b00;
            r_consumer    <= 1'b0;
            r_gap_cnt     <= '0;
            r_done_intr   <= 2'b00;
            r_err_wr_busy <= 1'b0;
        end else begin
            r_op_en       <= w_op_en_nxt;
            r_consumer    <= w_consumer_nxt;
            r_gap_cnt     <= w_gap_cnt_nxt;
            r_done_intr   <= w_done_intr_nxt;
            r_err_wr_busy <= w_err_wr_busy_nxt;
        end
    end

    // An accepted done implies op_en[consumer]=1, so a set can never hit the group being cleared.
    always_comb begin
        w_op_en_nxt       = r_op_en;
        w_consumer_nxt    = r_consumer;
        w_gap_cnt_nxt     = r_gap_cnt;
        w_done_intr_nxt   = 2'b00;
        w_err_wr_busy_nxt = w_wr_err;

        if (r_gap_cnt != '0) begin
            w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
        end

        if (w_done_acc) begin
            w_op_en_nxt[r_consumer]     = 1'b0;
            w_done_intr_nxt[r_consumer] = 1'b1;
            w_consumer_nxt              = ~r_consumer;
            w_gap_cnt_nxt               = GAP_LOAD;
        end

        if (w_wr_set) begin
            w_op_en_nxt[producer] = 1'b1;
        end
    end

    always_comb begin
        consumer     = r_consumer;
        op_en_0      = r_op_en[0];
        op_en_1      = r_op_en[1];
        status_0     = f_status(r_op_en[0], r_consumer == 1'b0);
        status_1     = f_status(r_op_en[1], r_consumer == 1'b1);
        reg2dp_op_en = w_run;
        done_intr    = r_done_intr;
        err_wr_busy  = r_err_wr_busy;
    end

endmodule
